lms_ctr_flash_read_seq: RTL and testbench
=========================================

// Module: lms_ctr_flash_read_seq
// PURPOSE
// Hardware read sequencer for the active-serial config flash. Issues a READ (0x03) + 24-bit address,
// then clocks out N data bytes, by driving the register port of the FPGA_AS SPI master
// (regs: 0 rxdata, 1 txdata, 3 control, 5 slave-select). Sits directly upstream of that core;
// streams received bytes downstream on a valid/ready byte interface. Replaces CPU byte-banging.
// PARAMETERS
// CMD_READ   8'h03      flash read opcode
// SS_MASK    16'h0001   value written to slave-select reg (addr 5)
// LEN_W      16         width of byte-count input
// BIT_REV    1          1: bit-reverse every tx/rx byte (SPI core shifts LSB-first, flash is MSB-first)
// PORTS
// clk              in   1      system clock (same as SPI core)
// reset_n          in   1      asynchronous, active-low reset
// start            in   1      1-cycle request; sampled only in IDLE
// start_addr       in   24     flash byte address
// start_len        in   LEN_W  bytes to read; 0 = no transfer
// busy             out  1      high from accepted start until done
// done             out  1      1-cycle pulse at end of sequence
// out_data         out  8      received byte (MSB-first corrected)
// out_valid        out  1      out_data valid; held until out_ready
// out_ready        in   1      downstream accepts byte
// spi_select       out  1      SPI core chip-select (register port)
// spi_mem_addr     out  3      SPI core register address
// spi_wdata        out  16     to SPI core data_from_cpu
// spi_write_n      out  1      active-low write
// spi_read_n       out  1      active-low read
// spi_rdata        in   16     from SPI core data_to_cpu
// spi_rrdy         in   1      SPI core dataavailable
// spi_trdy         in   1      SPI core readyfordata
// BEHAVIOUR
// - Reset: busy=0 done=0 out_valid=0 out_data=0 spi_select=0 spi_write_n=1 spi_read_n=1 spi_mem_addr=0 spi_wdata=0; FSM=IDLE.
// - Bus access = 2 cycles: spi_select=1 and write_n/read_n=0 for exactly 2 clk, then >=1 idle cycle (all deasserted).
//   Read data captured from spi_rdata[7:0] on the edge ending access cycle 2.
// - FSM: IDLE -> (start, len!=0) SET_SS: write addr5=SS_MASK -> SSO_ON: write addr3=16'h0400
//   -> CMD_WR (wait spi_trdy; write addr1 byte k) -> CMD_WAIT (wait spi_rrdy) -> CMD_RD (read addr0, discard);
//   k=0..3: CMD_READ, addr[23:16], addr[15:8], addr[7:0]
//   -> DAT_WR (write addr1=0x00) -> DAT_WAIT (spi_rrdy) -> DAT_RD (read addr0) -> OUT (out_valid=1 until out_ready)
//   -> DAT_WR while remaining!=0, else SSO_OFF: write addr3=16'h0000 -> DONE (done=1 one cycle) -> IDLE.
// - start with len==0: no bus access; done pulses the cycle after start; busy high that one cycle.
// - start while busy: ignored. start_addr/start_len latched on accepted start only.
// - One byte in flight: next dummy write not issued until OUT handshake completes (SCLK idles, SS stays low).
// - out_valid/out_data stable while out_valid & !out_ready; out_valid drops the cycle after handshake.
// - Remaining counter LEN_W bits, decremented on each DAT_RD; start_len=2^LEN_W-1 supported, no wrap.
// - BIT_REV=1: tx byte reversed before spi_wdata[7:0]; rx byte reversed before out_data. spi_wdata[15:8]=0.
// - Wait states have no timeout; reset_n mid-sequence returns to IDLE at once (SPI core shares reset, SS releases).
// TESTING
// 1 Reset: all outputs at reset values; no spi_select activity for 20 cycles with start=0.
// 2 start addr=0x123456 len=3, BIT_REV=1, SPI model echoes 0xA1,0xB2,0xC3 -> tx bytes rev(03,12,34,56,00,00,00),
//   out_data 0xA1,0xB2,0xC3 (after model-side reversal), addr3 0x0400 before first tx, 0x0000 after last, done once.
// 3 Backpressure: out_ready=0 for 50 cycles on byte 2 -> out_valid/out_data held, no addr1 write until accept.
// 4 start len=0 -> done the next cycle, zero bus accesses; start pulses during busy -> ignored, single done.
// 5 spi_trdy/spi_rrdy held low 100 cycles -> FSM waits, strobes never exceed 2 cycles, no extra access.
// 6 reset_n asserted mid-data byte -> next cycle busy=0, out_valid=0, spi_select=0; new start runs cleanly.

Source files
------------

// File: rtl/lms_ctr_flash_read_seq.sv
// lms_ctr_flash_read_seq: hardware READ sequencer for the active-serial config flash via the FPGA_AS SPI master register port
// Ports: clk, reset_n (async, active-low)
//   start/start_addr/start_len : request, sampled only while idle (len 0 = no transfer)
//   busy, done                 : busy from accepted start through the done pulse
//   out_data/out_valid/out_ready : received bytes, held until accepted
//   spi_*                      : register-port master into the SPI core (addr 0 rx, 1 tx, 3 control, 5 slave-select)
module lms_ctr_flash_read_seq #(
    parameter logic [7:0]  CMD_READ = 8'h03,
    parameter logic [15:0] SS_MASK  = 16'h0001,
    parameter int          LEN_W    = 16,
    parameter bit          BIT_REV  = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [23:0]      start_addr,
    input  logic [LEN_W-1:0] start_len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             spi_select,
    output logic [2:0]       spi_mem_addr,
    output logic [15:0]      spi_wdata,
    output logic             spi_write_n,
    output logic             spi_read_n,
    input  logic [15:0]      spi_rdata,
    input  logic             spi_rrdy,
    input  logic             spi_trdy
);
    typedef enum logic [3:0] {
        IDLE, SET_SS, SSO_ON, CMD_WR, CMD_WAIT, CMD_RD,
        DAT_WR, DAT_WAIT, DAT_RD, OUT, SSO_OFF, DONE
    } state_t;
    state_t state, state_nx;
    logic [1:0] ph, ph_nx, k;
    logic [23:0] addr;
    logic [LEN_W-1:0] rem;
    logic wr, acc, go, last, strobe;
    logic [7:0] tx;
    logic unused_hi;
    assign unused_hi = ^spi_rdata[15:8];
    // The SPI core shifts LSB-first while the flash expects MSB-first.
    function automatic logic [7:0] fix(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return BIT_REV ? r : b;
    endfunction
    // Every bus state runs ph 0 (wait for go), 1-2 (strobes asserted), 3 (idle gap).
    always_comb begin
        wr = state inside {SET_SS, SSO_ON, CMD_WR, DAT_WR, SSO_OFF};
        acc = wr || state inside {CMD_RD, DAT_RD};
        go = (state == CMD_WR || state == DAT_WR) ? spi_trdy : 1'b1;
        last = ph == 2'd3;
        strobe = acc && (ph[0] ^ ph[1]);
        tx = (state == DAT_WR) ? 8'h00 : (k == 2'd0) ? CMD_READ : (k == 2'd1) ? addr[23:16] :
             (k == 2'd2) ? addr[15:8] : addr[7:0];
        ph_nx = acc ? ((ph == 2'd0 && !go) ? 2'd0 : ph + 2'd1) : 2'd0;
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = (start_len == '0) ? DONE : SET_SS;
            SET_SS:   if (last) state_nx = SSO_ON;
            SSO_ON:   if (last) state_nx = CMD_WR;
            CMD_WR:   if (last) state_nx = CMD_WAIT;
            CMD_WAIT: if (spi_rrdy) state_nx = CMD_RD;
            CMD_RD:   if (last) state_nx = (k == 2'd3) ? DAT_WR : CMD_WR;
            DAT_WR:   if (last) state_nx = DAT_WAIT;
            DAT_WAIT: if (spi_rrdy) state_nx = DAT_RD;
            DAT_RD:   if (last) state_nx = OUT;
            OUT:      if (out_ready) state_nx = (rem != '0) ? DAT_WR : SSO_OFF;
            SSO_OFF:  if (last) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        busy = state != IDLE;
        done = state == DONE;
        out_valid = state == OUT;
        spi_select = strobe;
        spi_write_n = !(strobe && wr);
        spi_read_n = !(strobe && !wr);
        spi_mem_addr = !strobe ? 3'd0 : (state == SET_SS) ? 3'd5 :
                       (state == SSO_ON || state == SSO_OFF) ? 3'd3 :
                       (state == CMD_WR || state == DAT_WR) ? 3'd1 : 3'd0;
        spi_wdata = !(strobe && wr) ? 16'h0000 : (state == SET_SS) ? SS_MASK :
                    (state == SSO_ON) ? 16'h0400 : (state == SSO_OFF) ? 16'h0000 : {8'h00, fix(tx)};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ph <= 2'd0;
            k <= 2'd0;
            addr <= 24'h0;
            rem <= '0;
            out_data <= 8'h00;
        end else begin
            state <= state_nx;
            ph <= ph_nx;
            if (state == IDLE && start) begin
                addr <= start_addr;
                rem <= start_len;
                k <= 2'd0;
            end
            if (state == CMD_RD && last) k <= k + 2'd1;
            // Capture on the edge ending the second read strobe cycle.
            if (state == DAT_RD && ph == 2'd2) begin
                out_data <= fix(spi_rdata[7:0]);
                rem <= rem - LEN_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_lms_ctr_flash_read_seq.sv
// tb_lms_ctr_flash_read_seq: randomized bench with a behavioural SPI-core model and an access-list reference model
// Ports: none (top-level bench driving clk/reset_n and every DUT port)
module tb_lms_ctr_flash_read_seq;
    typedef struct packed {logic wr; logic [2:0] a; logic [15:0] d;} acc_t;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [23:0] start_addr = 24'h0;
    logic [15:0] start_len = 16'h0;
    logic busy, done, out_valid, spi_select, spi_write_n, spi_read_n, spi_rrdy, spi_trdy;
    logic [7:0] out_data;
    logic [2:0] spi_mem_addr;
    logic [15:0] spi_wdata, spi_rdata;
    int total = 0, bad = 0, proto_err = 0, done_cnt = 0;
    logic [7:0] rx_data [256];
    acc_t log_q[$];
    logic [7:0] got_q[$];
    logic trdy_en = 1'b1, rrdy_en = 1'b1, pend_o, rrdy_o;
    int run, wcnt, rx_pos, dly;
    bit pend_s, rrdy_s, prev_v, prev_r;
    logic [7:0] nxt, prev_d;

    lms_ctr_flash_read_seq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr), .start_len(start_len),
        .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .spi_select(spi_select), .spi_mem_addr(spi_mem_addr), .spi_wdata(spi_wdata),
        .spi_write_n(spi_write_n), .spi_read_n(spi_read_n), .spi_rdata(spi_rdata),
        .spi_rrdy(spi_rrdy), .spi_trdy(spi_trdy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // SPI core model: logs accesses, enforces 2-cycle strobes, answers each tx byte after a random delay.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run = 0; pend_s = 0; rrdy_s = 0; wcnt = 0; rx_pos = 0;
            pend_o <= 1'b0; rrdy_o <= 1'b0; spi_rdata <= 16'h0;
        end else begin
            if (spi_select && (!spi_write_n || !spi_read_n)) begin
                run++;
                if (run == 1) begin
                    log_q.push_back({!spi_write_n, spi_mem_addr, spi_wdata});
                    if (!spi_write_n && spi_mem_addr == 3'd5) begin wcnt = 0; rx_pos = 0; end
                    if (!spi_write_n && spi_mem_addr == 3'd1) begin
                        if (pend_s || rrdy_s) proto_err++;
                        pend_s = 1;
                        dly = $urandom_range(0, 5);
                        nxt = (wcnt < 4) ? 8'hFF : rev(rx_data[rx_pos]);
                        if (wcnt >= 4) rx_pos++;
                        wcnt++;
                    end
                end
                if (run == 2 && !spi_read_n && spi_mem_addr == 3'd0) rrdy_s = 0;
                if (run > 2 || (!spi_write_n && !spi_read_n)) proto_err++;
            end else begin
                if (run != 0 && run != 2) proto_err++;
                run = 0;
            end
            if (pend_s) begin
                if (dly == 0) begin pend_s = 0; rrdy_s = 1; spi_rdata <= {8'h00, nxt}; end
                else dly--;
            end
            pend_o <= pend_s;
            rrdy_o <= rrdy_s;
        end
    end
    assign spi_trdy = trdy_en && !pend_o;
    assign spi_rrdy = rrdy_en && rrdy_o;

    // Output collector: handshakes, hold-while-stalled, drop-after-accept, done pulses.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_v = 0; prev_r = 0; prev_d = 8'h0;
        end else begin
            if (prev_v && !prev_r && (!out_valid || out_data !== prev_d)) proto_err++;
            if (prev_v && prev_r && out_valid) proto_err++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_cnt++;
            prev_v = out_valid; prev_r = out_ready; prev_d = out_data;
        end
    end

    task automatic run_xfer(input logic [23:0] a, input int n, input int bp, input bit poke,
                            input bit stall, input string name);
        acc_t exp_q[$];
        logic [7:0] cmd [4];
        logic [7:0] hd;
        int cyc, lsz;
        cmd = '{8'h03, a[23:16], a[15:8], a[7:0]};
        log_q.delete(); got_q.delete(); done_cnt = 0;
        @(negedge clk); start = 1; start_addr = a; start_len = n[15:0];
        @(negedge clk); start = 0; start_addr = $urandom; start_len = 16'($urandom);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start got=%b exp=1", name, busy); end
        cyc = 0;
        while (done_cnt == 0 && cyc < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            start = (poke && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (stall) begin
                if (cyc == 30) trdy_en = 0;
                if (cyc == 130) trdy_en = 1;
                if (cyc == 150) rrdy_en = 0;
                if (cyc == 250) rrdy_en = 1;
            end
            if (bp >= 0 && out_valid && got_q.size() == bp) begin
                hd = out_data; lsz = log_q.size(); out_ready = 0; start = 0;
                repeat (50) begin
                    @(negedge clk);
                    total++;
                    if (out_valid !== 1'b1 || out_data !== hd || log_q.size() != lsz) begin
                        bad++;
                        $display("FAIL %s hold got v=%b d=%h acc=%0d exp v=1 d=%h acc=%0d",
                                 name, out_valid, out_data, log_q.size(), hd, lsz);
                    end
                end
                bp = -1;
                out_ready = 1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 0; out_ready = 0; trdy_en = 1; rrdy_en = 1;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != 1) begin bad++; $display("FAIL %s done_count got=%0d exp=1", name, done_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_end got=%b exp=0", name, busy); end
        total++;
        if (got_q.size() != n) begin bad++; $display("FAIL %s byte_count got=%0d exp=%0d", name, got_q.size(), n); end
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== rx_data[i]) begin
                bad++; $display("FAIL %s byte[%0d] got=%h exp=%h", name, i, got_q[i], rx_data[i]);
            end
        end
        if (n != 0) begin
            exp_q.push_back({1'b1, 3'd5, 16'h0001});
            exp_q.push_back({1'b1, 3'd3, 16'h0400});
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back({1'b1, 3'd1, 8'h00, rev(cmd[i])});
                exp_q.push_back({1'b0, 3'd0, 16'h0});
            end
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({1'b1, 3'd1, 16'h0000});
                exp_q.push_back({1'b0, 3'd0, 16'h0});
            end
            exp_q.push_back({1'b1, 3'd3, 16'h0000});
        end
        total++;
        if (log_q.size() != exp_q.size()) begin
            bad++; $display("FAIL %s access_count got=%0d exp=%0d", name, log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            total++;
            if (log_q[i].wr !== exp_q[i].wr || log_q[i].a !== exp_q[i].a ||
                (exp_q[i].wr && log_q[i].d !== exp_q[i].d)) begin
                bad++;
                $display("FAIL %s access[%0d] got wr=%b a=%0d d=%h exp wr=%b a=%0d d=%h", name, i,
                         log_q[i].wr, log_q[i].a, log_q[i].d, exp_q[i].wr, exp_q[i].a, exp_q[i].d);
            end
        end
        total++;
        if (proto_err != 0) begin bad++; $display("FAIL %s protocol_errors got=%0d exp=0", name, proto_err); end
    endtask

    task automatic test_reset();
        int sel;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, out_valid, out_data, spi_select, spi_write_n, spi_read_n, spi_mem_addr, spi_wdata}
            !== {3'b000, 8'h00, 3'b011, 3'd0, 16'h0}) begin
            bad++; $display("FAIL reset_outputs got busy=%b done=%b v=%b d=%h sel=%b wn=%b rn=%b a=%0d wd=%h",
                            busy, done, out_valid, out_data, spi_select, spi_write_n, spi_read_n, spi_mem_addr, spi_wdata);
        end
        reset_n = 1;
        sel = 0;
        repeat (20) begin @(negedge clk); if (spi_select || busy || done) sel++; end
        total++;
        if (sel != 0) begin bad++; $display("FAIL reset_idle activity_cycles got=%0d exp=0", sel); end
    endtask

    task automatic test_basic();
        rx_data[0] = 8'hA1; rx_data[1] = 8'hB2; rx_data[2] = 8'hC3;
        run_xfer(24'h123456, 3, -1, 0, 0, "basic");
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 256; i++) rx_data[i] = 8'($urandom);
            run_xfer(24'($urandom), $urandom_range(1, 8), -1, 0, 0, "random");
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 256; i++) rx_data[i] = 8'($urandom);
        run_xfer(24'($urandom), 4, 1, 0, 0, "backpressure");
    endtask

    task automatic test_zero_len_and_ignore();
        log_q.delete(); done_cnt = 0;
        @(negedge clk); start = 1; start_addr = 24'hABCDEF; start_len = 16'h0;
        @(negedge clk); start = 0;
        total++;
        if ({done, busy} !== 2'b11) begin bad++; $display("FAIL zero_len done_busy got=%b%b exp=11", done, busy); end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL zero_len after got=%b%b exp=00", done, busy); end
        repeat (3) @(negedge clk);
        total++;
        if (log_q.size() != 0 || done_cnt != 1) begin
            bad++; $display("FAIL zero_len accesses=%0d dones=%0d exp 0 and 1", log_q.size(), done_cnt);
        end
        for (int i = 0; i < 256; i++) rx_data[i] = 8'($urandom);
        run_xfer(24'($urandom), 5, -1, 1, 0, "ignore_start");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 256; i++) rx_data[i] = 8'($urandom);
        run_xfer(24'($urandom), 12, -1, 0, 1, "stall");
    endtask

    task automatic test_reset_mid();
        int cyc;
        for (int i = 0; i < 256; i++) rx_data[i] = 8'($urandom);
        got_q.delete();
        @(negedge clk); start = 1; start_addr = 24'h00F00D; start_len = 16'd6;
        @(negedge clk); start = 0;
        cyc = 0;
        while (got_q.size() < 2 && cyc < 2000) begin
            out_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            cyc++;
        end
        total++;
        if (got_q.size() < 2) begin bad++; $display("FAIL reset_mid timeout bytes=%0d exp>=2", got_q.size()); end
        repeat ($urandom_range(1, 6)) @(negedge clk);
        #2 reset_n = 0;
        #1;
        total++;
        if ({busy, out_valid, spi_select} !== 3'b000) begin
            bad++; $display("FAIL reset_mid outputs got busy=%b v=%b sel=%b exp 000", busy, out_valid, spi_select);
        end
        @(negedge clk);
        total++;
        if ({busy, out_valid, spi_select, done} !== 4'b0000) begin
            bad++; $display("FAIL reset_mid held got busy=%b v=%b sel=%b done=%b", busy, out_valid, spi_select, done);
        end
        out_ready = 0;
        reset_n = 1;
        for (int i = 0; i < 256; i++) rx_data[i] = 8'($urandom);
        run_xfer(24'($urandom), 3, -1, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_zero_len_and_ignore();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
